bsram_pipe: RTL and testbench

Parametrised successor to the project's single-read/single-write block RAM, used for game data, VRAM and stack memories. Adds byte-enable writes, optional write-first forwarding, a selectable 1- or 2-cycle read latency with valid tracking, and a hardware clear sequencer. The sequencer zeroes the array after reset or on request, for example between game loads.

---
 rtl/bsram_pipe_pkg.sv | 18 +
 rtl/bsram_pipe_core.sv | 51 +++++
 rtl/bsram_pipe.sv | 166 ++++++++++++++++
 tb/tb_bsram_pipe.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bsram_pipe_pkg.sv
// Shared types and defaults for the pipelined block RAM with clear sequencer.
package bsram_pipe_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_ADDR_WIDTH = 12;
    localparam int DEFAULT_SIZE       = 4096;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } bsram_state_t;

    // Number of byte lanes in a word of the given width.
    function automatic int byte_count(input int width);
        return width / 8;
    endfunction

endpackage

// File: rtl/bsram_pipe_core.sv
// Bare byte-enable array: one synchronous write port, one synchronous
// read-first read port. Kept free of pipeline logic so block-RAM mapping
// stays confined to this file.
module bsram_pipe_core
    import bsram_pipe_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int SIZE       = DEFAULT_SIZE,
    parameter int NB         = byte_count(DATA_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [NB-1:0]         wbe,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);

    logic [DATA_WIDTH-1:0] mem [SIZE];
    logic                  rd_in_range;

    assign rd_in_range = ({1'b0, raddr} < SIZE_W);

    // Byte-lane write; the caller only asserts we for in-range addresses.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int i = 0; i < NB; i++) begin
                if (wbe[i]) begin
                    mem[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
                end
            end
        end
    end

    // Read-first registered read; out-of-range addresses return zero and
    // the register holds when no read is requested.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= rd_in_range ? mem[raddr] : '0;
        end
    end

endmodule

// File: rtl/bsram_pipe.sv
// Pipelined block RAM: byte-enable writes, optional write-first forwarding,
// 1- or 2-cycle read latency with valid tracking and a clear sequencer.
//
//   state | meaning
//   IDLE  | user reads and writes accepted
//   CLEAR | zeroing one word per cycle, user access ignored, busy=1
module bsram_pipe
    import bsram_pipe_pkg::*;
#(
    parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
    parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
    parameter int SIZE           = DEFAULT_SIZE,
    parameter int OUT_REG        = 0,
    parameter int BYPASS         = 1,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          clear_req,
    output logic                          busy,
    input  logic                          re,
    input  logic [ADDR_WIDTH-1:0]         mem_dout_addr,
    output logic [DATA_WIDTH-1:0]         mem_dout,
    output logic                          mem_dout_valid,
    input  logic                          we,
    input  logic [DATA_WIDTH/8-1:0]       be,
    input  logic [ADDR_WIDTH-1:0]         mem_din_addr,
    input  logic [DATA_WIDTH-1:0]         mem_din
);

    localparam int                  NB     = byte_count(DATA_WIDTH);
    localparam logic [ADDR_WIDTH:0] SIZE_W = (ADDR_WIDTH + 1)'(SIZE);
    localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);

    bsram_state_t          state, state_nxt;
    logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
    logic                  clr_we;

    logic                  user_wr, user_rd;
    logic                  core_we;
    logic [NB-1:0]         core_be;
    logic [ADDR_WIDTH-1:0] core_waddr;
    logic [DATA_WIDTH-1:0] core_wdata;
    logic [DATA_WIDTH-1:0] core_rdata;

    logic                  s1_valid;
    logic                  fwd_hit;
    logic [NB-1:0]         fwd_be;
    logic [DATA_WIDTH-1:0] fwd_data;
    logic [DATA_WIDTH-1:0] merged;

    // Sequencer state and clear counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: start on clear_req, leave on the cycle that zeroes the last word.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_we    = 1'b0;
        case (state)
            IDLE: begin
                if (clear_req) begin
                    state_nxt = CLEAR;
                    cnt_nxt   = '0;
                end
            end
            CLEAR: begin
                clr_we = 1'b1;
                if (cnt == LAST) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign busy    = (state == CLEAR);
    assign user_wr = we & ~busy & ({1'b0, mem_din_addr} < SIZE_W);
    assign user_rd = re & ~busy;

    assign core_we    = clr_we | user_wr;
    assign core_be    = clr_we ? '1 : be;
    assign core_waddr = clr_we ? cnt : mem_din_addr;
    assign core_wdata = clr_we ? '0 : mem_din;

    bsram_pipe_core #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .SIZE       (SIZE),
        .NB         (NB)
    ) u_core (
        .clk   (clk),
        .rst   (reset),
        .we    (core_we),
        .wbe   (core_be),
        .waddr (core_waddr),
        .wdata (core_wdata),
        .re    (user_rd),
        .raddr (mem_dout_addr),
        .rdata (core_rdata)
    );

    // First read stage: capture forwarding info alongside the array read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_valid <= 1'b0;
            fwd_hit  <= 1'b0;
            fwd_be   <= '0;
            fwd_data <= '0;
        end else begin
            s1_valid <= user_rd;
            if (user_rd) begin
                fwd_hit  <= (BYPASS != 0) && user_wr && (mem_din_addr == mem_dout_addr);
                fwd_be   <= be;
                fwd_data <= mem_din;
            end
        end
    end

    // Replace the enabled bytes of the old word when a same-address write was forwarded.
    always_comb begin
        merged = core_rdata;
        for (int i = 0; i < NB; i++) begin
            if (fwd_hit && fwd_be[i]) begin
                merged[i*8 +: 8] = fwd_data[i*8 +: 8];
            end
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] out_q;
            logic                  valid_q;

            // Second stage: register data only when a valid read is passing through.
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    out_q   <= '0;
                    valid_q <= 1'b0;
                end else begin
                    valid_q <= s1_valid;
                    if (s1_valid) begin
                        out_q <= merged;
                    end
                end
            end

            assign mem_dout       = out_q;
            assign mem_dout_valid = valid_q;
        end else begin : g_no_out_reg
            assign mem_dout       = merged;
            assign mem_dout_valid = s1_valid;
        end
    endgenerate

endmodule

// File: tb/tb_bsram_pipe.sv
// Directed bench for bsram_pipe: three instances (latency 1 write-first,
// latency 2 write-first, latency 1 read-first) share one stimulus stream and
// are checked against a reference memory through per-instance scoreboards.
module tb_bsram_pipe;

    localparam int DW = 16;
    localparam int AW = 5;
    localparam int SZ = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          clear_req;
    logic          re, we;
    logic [1:0]    be;
    logic [AW-1:0] raddr, waddr;
    logic [DW-1:0] din;

    logic          busy0, busy1, busy2;
    logic [DW-1:0] d0, d1, d2;
    logic          v0, v1, v2;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            due;
    } exp_t;

    exp_t          q0[$];
    exp_t          q1[$];
    exp_t          q2[$];
    logic [DW-1:0] mdl [SZ];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    bsram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ), .OUT_REG(0), .BYPASS(1), .CLEAR_ON_RESET(1)) u0 (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy0),
        .re(re), .mem_dout_addr(raddr), .mem_dout(d0), .mem_dout_valid(v0),
        .we(we), .be(be), .mem_din_addr(waddr), .mem_din(din));

    bsram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ), .OUT_REG(1), .BYPASS(1), .CLEAR_ON_RESET(1)) u1 (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy1),
        .re(re), .mem_dout_addr(raddr), .mem_dout(d1), .mem_dout_valid(v1),
        .we(we), .be(be), .mem_din_addr(waddr), .mem_din(din));

    bsram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SIZE(SZ), .OUT_REG(0), .BYPASS(0), .CLEAR_ON_RESET(1)) u2 (
        .clk(clk), .reset(reset), .clear_req(clear_req), .busy(busy2),
        .re(re), .mem_dout_addr(raddr), .mem_dout(d2), .mem_dout_valid(v2),
        .we(we), .be(be), .mem_din_addr(waddr), .mem_din(din));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        re = 1'b0;
        we = 1'b0;
        repeat (n) step();
    endtask

    task automatic chk_busy_all(input string tag, input logic exp);
        chk({tag, "_u0"}, busy0, exp);
        chk({tag, "_u1"}, busy1, exp);
        chk({tag, "_u2"}, busy2, exp);
    endtask

    // Drive one cycle of stimulus; when not busy, push expected read results
    // (forwarding and latency per instance) and update the reference memory.
    task automatic drive(input logic r, input logic [AW-1:0] ra, input logic w, input logic [1:0] b,
                         input logic [AW-1:0] wa, input logic [DW-1:0] wd, input logic busy_exp);
        logic [DW-1:0] old_w, mrg;
        exp_t          e;
        re = r; raddr = ra; we = w; be = b; waddr = wa; din = wd;
        if (!busy_exp) begin
            if (r) begin
                old_w = (ra < SZ) ? mdl[ra] : '0;
                mrg   = old_w;
                if (w && wa == ra && ra < SZ) begin
                    for (int i = 0; i < 2; i++) begin
                        if (b[i]) mrg[i*8 +: 8] = wd[i*8 +: 8];
                    end
                end
                e.data = mrg;   e.due = cyc + 1; q0.push_back(e);
                e.data = mrg;   e.due = cyc + 2; q1.push_back(e);
                e.data = old_w; e.due = cyc + 1; q2.push_back(e);
            end
            if (w && wa < SZ) begin
                for (int i = 0; i < 2; i++) begin
                    if (b[i]) mdl[wa][i*8 +: 8] = wd[i*8 +: 8];
                end
            end
        end
        step();
    endtask

    task automatic mon(input int k, input logic v, input logic [DW-1:0] d);
        exp_t e;
        int   n;
        n = 0;
        case (k)
            0: begin n = q0.size(); if (n > 0) e = q0[0]; end
            1: begin n = q1.size(); if (n > 0) e = q1[0]; end
            default: begin n = q2.size(); if (n > 0) e = q2[0]; end
        endcase
        if (v) begin
            if (n == 0) begin
                chk($sformatf("spurious_valid_u%0d", k), v, 1'b0);
            end else begin
                chk($sformatf("latency_u%0d", k), cyc, e.due);
                chk($sformatf("rdata_u%0d", k), d, e.data);
            end
        end else if (n > 0 && e.due <= cyc) begin
            chk($sformatf("missing_valid_u%0d", k), v, 1'b1);
        end
        if (n > 0 && (v || e.due <= cyc)) begin
            case (k)
                0: void'(q0.pop_front());
                1: void'(q1.pop_front());
                default: void'(q2.pop_front());
            endcase
        end
    endtask

    // Scoreboard: compare each valid output against the oldest expectation.
    always @(negedge clk) begin
        if (!reset) begin
            mon(0, v0, d0);
            mon(1, v1, d1);
            mon(2, v2, d2);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog timeout at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; clear_req = 1'b0; re = 1'b0; we = 1'b0;
        be = '0; raddr = '0; waddr = '0; din = '0;
        for (int a = 0; a < SZ; a++) mdl[a] = '0;

        // Reset values and automatic clear of SIZE cycles.
        repeat (2) @(posedge clk);
        #1;
        chk_busy_all("busy_in_reset", 1'b1);
        chk("dout_reset_u0", d0, 16'h0);
        chk("dout_reset_u1", d1, 16'h0);
        chk("valid_reset_u0", v0, 1'b0);
        chk("valid_reset_u1", v1, 1'b0);
        chk("valid_reset_u2", v2, 1'b0);
        reset = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            chk_busy_all($sformatf("busy_por_%0d", i), (i < 16));
            step();
        end
        for (int a = 0; a < SZ; a++) drive(1'b1, AW'(a), 1'b0, 2'b00, '0, '0, 1'b0);
        idle(3);

        // Byte-enable writes and read-after-write.
        drive(1'b0, '0, 1'b1, 2'b11, 5'd5, 16'hABCD, 1'b0);
        drive(1'b0, '0, 1'b1, 2'b01, 5'd5, 16'h0012, 1'b0);
        drive(1'b1, 5'd5, 1'b0, 2'b00, '0, '0, 1'b0);
        drive(1'b0, '0, 1'b1, 2'b00, 5'd5, 16'hFFFF, 1'b0);
        drive(1'b1, 5'd5, 1'b0, 2'b00, '0, '0, 1'b0);
        idle(3);

        // Same-cycle read/write collisions, then a different-address write.
        drive(1'b0, '0, 1'b1, 2'b11, 5'd7, 16'h1111, 1'b0);
        drive(1'b1, 5'd7, 1'b1, 2'b10, 5'd7, 16'h2200, 1'b0);
        drive(1'b1, 5'd7, 1'b0, 2'b00, '0, '0, 1'b0);
        drive(1'b1, 5'd7, 1'b1, 2'b11, 5'd8, 16'h5555, 1'b0);
        drive(1'b1, 5'd8, 1'b0, 2'b00, '0, '0, 1'b0);
        idle(3);

        // Back-to-back reads to exercise the two-stage pipeline.
        drive(1'b0, '0, 1'b1, 2'b11, 5'd1, 16'h0001, 1'b0);
        drive(1'b0, '0, 1'b1, 2'b11, 5'd2, 16'h0002, 1'b0);
        drive(1'b0, '0, 1'b1, 2'b11, 5'd3, 16'h0003, 1'b0);
        drive(1'b1, 5'd1, 1'b0, 2'b00, '0, '0, 1'b0);
        drive(1'b1, 5'd2, 1'b0, 2'b00, '0, '0, 1'b0);
        drive(1'b1, 5'd3, 1'b0, 2'b00, '0, '0, 1'b0);
        idle(4);

        // Fill, then requested clear with ignored user access during busy.
        for (int a = 0; a < SZ; a++) drive(1'b0, '0, 1'b1, 2'b11, AW'(a), 16'hFFFF, 1'b0);
        drive(1'b1, 5'd3, 1'b0, 2'b00, '0, '0, 1'b0);
        drive(1'b1, 5'd15, 1'b0, 2'b00, '0, '0, 1'b0);
        idle(3);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            chk_busy_all($sformatf("busy_clr_%0d", i), (i < 16));
            if (i == 2 || i == 9) begin
                clear_req = (i == 9);
                drive(1'b1, 5'd3, 1'b1, 2'b11, 5'd3, 16'h1234, 1'b1);
                clear_req = 1'b0;
            end else begin
                idle(1);
            end
        end
        for (int a = 0; a < SZ; a++) mdl[a] = '0;
        for (int a = 0; a < SZ; a++) drive(1'b1, AW'(a), 1'b0, 2'b00, '0, '0, 1'b0);
        idle(3);

        // Reset in the middle of a clear restarts the full sequence.
        for (int a = 12; a < SZ; a++) drive(1'b0, '0, 1'b1, 2'b11, AW'(a), 16'hBEEF, 1'b0);
        drive(1'b1, 5'd13, 1'b0, 2'b00, '0, '0, 1'b0);
        idle(3);
        clear_req = 1'b1;
        step();
        clear_req = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk_busy_all($sformatf("busy_pre_rst_%0d", i), 1'b1);
            idle(1);
        end
        reset = 1'b1;
        #2;
        chk_busy_all("busy_mid_rst", 1'b1);
        chk("dout_mid_rst_u0", d0, 16'h0);
        chk("dout_mid_rst_u1", d1, 16'h0);
        chk("dout_mid_rst_u2", d2, 16'h0);
        step();
        reset = 1'b0;
        for (int i = 0; i <= 16; i++) begin
            chk_busy_all($sformatf("busy_restart_%0d", i), (i < 16));
            step();
        end
        for (int a = 0; a < SZ; a++) mdl[a] = '0;
        for (int a = 10; a < SZ; a++) drive(1'b1, AW'(a), 1'b0, 2'b00, '0, '0, 1'b0);

        // Out-of-range write is dropped and out-of-range read returns zero.
        drive(1'b0, '0, 1'b1, 2'b11, 5'd20, 16'hDEAD, 1'b0);
        drive(1'b1, 5'd20, 1'b0, 2'b00, '0, '0, 1'b0);
        drive(1'b1, 5'd4, 1'b0, 2'b00, '0, '0, 1'b0);
        drive(1'b1, 5'd20, 1'b1, 2'b11, 5'd20, 16'hDEAD, 1'b0);
        idle(4);

        chk("sb_empty_u0", q0.size(), 0);
        chk("sb_empty_u1", q1.size(), 0);
        chk("sb_empty_u2", q2.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
